// File: rtl/rtc_alarm_bank.sv
// ---------------------------------------------------------------------------
// rtc_alarm_bank
//   Real-time clock (hh:mm:ss, binary fields) with a bank of independent
//   daily alarm channels. Each channel has a small IDLE / RINGING / SNOOZE
//   state machine, a ring-timeout counter and (optionally) a snooze counter.
//
// Build option:
//   RTC_ALARM_SNOOZE_EN  defined   -> SNOOZE state, snooze counters and the
//                                     snooze port are active.
//                        undefined -> snooze port exists but is ignored; no
//                                     SNOOZE state or counter is built.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   tick              one-clk pulse, advance time by one second
//   time_set/time_in  load {hour[16:12], min[11:6], sec[5:0]}; invalid ignored
//   alarm_wr/alarm_sel/alarm_in
//                     write {enable[11], hour[10:6], min[5:0]} to a channel
//   ack, snooze       per-channel level-sampled acknowledge / snooze
//   hour_out/min_out/sec_out   current time (registered)
//   end_of_day        one-clk pulse on 23:59:59 -> 00:00:00 tick rollover
//   ringing           per-channel, high while channel is RINGING
//   alarm_irq         one-clk pulse when any channel enters RINGING
// ---------------------------------------------------------------------------
module rtc_alarm_bank #(
  parameter  int unsigned NUM_ALARMS   = 4,
  parameter  int unsigned RING_SECONDS = 60,
  parameter  int unsigned SNOOZE_MIN   = 5,
  localparam int unsigned ASW          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  time_set,
  input  logic [16:0]           time_in,
  input  logic                  alarm_wr,
  input  logic [ASW-1:0]        alarm_sel,
  input  logic [11:0]           alarm_in,
  input  logic [NUM_ALARMS-1:0] ack,
  input  logic [NUM_ALARMS-1:0] snooze,
  output logic [4:0]            hour_out,
  output logic [5:0]            min_out,
  output logic [5:0]            sec_out,
  output logic                  end_of_day,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  alarm_irq
);

  localparam int unsigned HW  = 5;
  localparam int unsigned MW  = 6;
  localparam int unsigned SW  = 6;
  localparam int unsigned AW  = 12;
  localparam int unsigned RCW = 8;
  localparam logic [RCW-1:0] RING_LAST = RCW'(RING_SECONDS - 1);
`ifdef RTC_ALARM_SNOOZE_EN
  localparam int unsigned SCW = 12;
  localparam logic [SCW-1:0] SNOOZE_LOAD = SCW'(SNOOZE_MIN * 60);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1
`ifdef RTC_ALARM_SNOOZE_EN
    ,
    ST_SNOOZE  = 2'd2
`endif
  } state_e;

  // ---------------------------------------------------------------- time
  logic [HW-1:0] hour_q, hour_d;
  logic [MW-1:0] min_q, min_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          eod_q, eod_d;
  // set when the last register update of the time came from a tick
  logic          tick_upd_q, tick_upd_d;
  logic          load_ok_c;

  // --------------------------------------------------------------- alarms
  logic [NUM_ALARMS-1:0][AW-1:0]  alarm_q, alarm_d;
  logic [NUM_ALARMS-1:0][1:0]     state_q, state_d;
  logic [NUM_ALARMS-1:0][RCW-1:0] ring_cnt_q, ring_cnt_d;
`ifdef RTC_ALARM_SNOOZE_EN
  logic [NUM_ALARMS-1:0][SCW-1:0] snz_cnt_q, snz_cnt_d;
`else
  logic [NUM_ALARMS-1:0]          snooze_unused;
  assign snooze_unused = snooze;
`endif
  logic [NUM_ALARMS-1:0]          ringing_q, ringing_d;
  logic                           irq_q, irq_d;
  logic                           wr_ok_c;
  logic [NUM_ALARMS-1:0]          match_c;

  // Time-of-day next state: valid load wins over tick; invalid load is dropped.
  always_comb begin
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    eod_d      = 1'b0;
    tick_upd_d = 1'b0;
    load_ok_c  = time_set &&
                 (time_in[16:12] <= 5'd23) &&
                 (time_in[11:6]  <= 6'd59) &&
                 (time_in[5:0]   <= 6'd59);
    if (load_ok_c) begin
      hour_d = time_in[16:12];
      min_d  = time_in[11:6];
      sec_d  = time_in[5:0];
    end else if (tick) begin
      tick_upd_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          if (hour_q == 5'd23) begin
            hour_d = '0;
            eod_d  = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Per-channel match: only a tick-driven update landing on hh:mm:00 counts.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match_c[i] = tick_upd_q && (sec_q == 6'd0) &&
                   (hour_q == alarm_q[i][10:6]) &&
                   (min_q  == alarm_q[i][5:0]);
    end
  end

  // Channel FSMs: write > disable > state behaviour.
  always_comb begin
    alarm_d    = alarm_q;
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
`ifdef RTC_ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
`endif
    ringing_d  = '0;
    irq_d      = 1'b0;
    wr_ok_c    = alarm_wr &&
                 (alarm_in[10:6] <= 5'd23) &&
                 (alarm_in[5:0]  <= 6'd59) &&
                 (32'(alarm_sel) < NUM_ALARMS);

    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (wr_ok_c && (alarm_sel == ASW'(i))) begin
        alarm_d[i]    = alarm_in;
        state_d[i]    = ST_IDLE;
        ring_cnt_d[i] = '0;
`ifdef RTC_ALARM_SNOOZE_EN
        snz_cnt_d[i]  = '0;
`endif
      end else if (!alarm_q[i][11]) begin
        state_d[i]    = ST_IDLE;
        ring_cnt_d[i] = '0;
`ifdef RTC_ALARM_SNOOZE_EN
        snz_cnt_d[i]  = '0;
`endif
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (match_c[i]) begin
              state_d[i]    = ST_RINGING;
              ring_cnt_d[i] = '0;
              irq_d         = 1'b1;
            end
          end
          ST_RINGING: begin
            // ack outranks snooze when both are held
            if (ack[i]) begin
              state_d[i]    = ST_IDLE;
              ring_cnt_d[i] = '0;
`ifdef RTC_ALARM_SNOOZE_EN
            end else if (snooze[i]) begin
              state_d[i]    = ST_SNOOZE;
              ring_cnt_d[i] = '0;
              snz_cnt_d[i]  = SNOOZE_LOAD;
`endif
            end else if (tick) begin
              if (ring_cnt_q[i] == RING_LAST) begin
                state_d[i]    = ST_IDLE;
                ring_cnt_d[i] = '0;
              end else begin
                ring_cnt_d[i] = ring_cnt_q[i] + RCW'(1);
              end
            end
          end
`ifdef RTC_ALARM_SNOOZE_EN
          ST_SNOOZE: begin
            if (ack[i]) begin
              state_d[i]   = ST_IDLE;
              snz_cnt_d[i] = '0;
            end else if (tick) begin
              // counter about to reach zero: re-ring with a fresh timeout
              if (snz_cnt_q[i] == SCW'(1)) begin
                state_d[i]    = ST_RINGING;
                snz_cnt_d[i]  = '0;
                ring_cnt_d[i] = '0;
                irq_d         = 1'b1;
              end else begin
                snz_cnt_d[i] = snz_cnt_q[i] - SCW'(1);
              end
            end
          end
`endif
          default: begin
            state_d[i]    = ST_IDLE;
            ring_cnt_d[i] = '0;
          end
        endcase
      end
      ringing_d[i] = (state_d[i] == ST_RINGING);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      eod_q      <= 1'b0;
      tick_upd_q <= 1'b0;
      alarm_q    <= '0;
      state_q    <= '0;
      ring_cnt_q <= '0;
`ifdef RTC_ALARM_SNOOZE_EN
      snz_cnt_q  <= '0;
`endif
      ringing_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      eod_q      <= eod_d;
      tick_upd_q <= tick_upd_d;
      alarm_q    <= alarm_d;
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
`ifdef RTC_ALARM_SNOOZE_EN
      snz_cnt_q  <= snz_cnt_d;
`endif
      ringing_q  <= ringing_d;
      irq_q      <= irq_d;
    end
  end

  assign hour_out   = hour_q;
  assign min_out    = min_q;
  assign sec_out    = sec_q;
  assign end_of_day = eod_q;
  assign ringing    = ringing_q;
  assign alarm_irq  = irq_q;

endmodule

// File: tb/tb_rtc_alarm_bank.sv
// ---------------------------------------------------------------------------
// tb_rtc_alarm_bank
//   Self-checking bench for rtc_alarm_bank: a table of time-keeping vectors,
//   hand-written alarm sequences, and a randomized phase compared every cycle
//   against a seconds-of-day reference model.
// ---------------------------------------------------------------------------
module tb_rtc_alarm_bank;
  localparam int unsigned NA = 4;
  localparam int unsigned RS = 60;
  localparam int unsigned SM = 5;
  localparam int unsigned OW = 19 + NA;
`ifdef RTC_ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          time_set;
  logic [16:0]   time_in;
  logic          alarm_wr;
  logic [1:0]    alarm_sel;
  logic [11:0]   alarm_in;
  logic [NA-1:0] ack;
  logic [NA-1:0] snooze;
  logic [4:0]    hour_out;
  logic [5:0]    min_out;
  logic [5:0]    sec_out;
  logic          end_of_day;
  logic [NA-1:0] ringing;
  logic          alarm_irq;
  logic [OW-1:0] dut_vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rtc_alarm_bank #(.NUM_ALARMS(NA), .RING_SECONDS(RS), .SNOOZE_MIN(SM)) dut (
    .clk(clk), .reset(reset), .tick(tick), .time_set(time_set),
    .time_in(time_in), .alarm_wr(alarm_wr), .alarm_sel(alarm_sel),
    .alarm_in(alarm_in), .ack(ack), .snooze(snooze),
    .hour_out(hour_out), .min_out(min_out), .sec_out(sec_out),
    .end_of_day(end_of_day), .ringing(ringing), .alarm_irq(alarm_irq)
  );

  assign dut_vec = {hour_out, min_out, sec_out, end_of_day, ringing, alarm_irq};

  // ------------------------------------------------------ reference model
  // Time kept as seconds since midnight; channel state 0 idle, 1 ring, 2 snooze.
  int m_t;
  bit m_eod, m_pend, m_irq;
  bit m_en [NA];
  int m_ah [NA];
  int m_am [NA];
  int m_st [NA];
  int m_rt [NA];
  int m_sl [NA];

  function automatic void model_reset();
    m_t = 0; m_eod = 0; m_pend = 0; m_irq = 0;
    for (int i = 0; i < NA; i++) begin
      m_en[i] = 0; m_ah[i] = 0; m_am[i] = 0; m_st[i] = 0; m_rt[i] = 0; m_sl[i] = 0;
    end
  endfunction

  function automatic void model_update();
    bit ld_ok, wr_ok, irq, match;
    ld_ok = time_set && (int'(time_in[16:12]) <= 23) &&
            (int'(time_in[11:6]) <= 59) && (int'(time_in[5:0]) <= 59);
    wr_ok = alarm_wr && (int'(alarm_in[10:6]) <= 23) &&
            (int'(alarm_in[5:0]) <= 59) && (int'(alarm_sel) < int'(NA));
    irq = 0;
    for (int i = 0; i < NA; i++) begin
      match = m_pend && (m_t == m_ah[i] * 3600 + m_am[i] * 60);
      if (wr_ok && int'(alarm_sel) == i) begin
        m_en[i] = alarm_in[11];
        m_ah[i] = int'(alarm_in[10:6]);
        m_am[i] = int'(alarm_in[5:0]);
        m_st[i] = 0;
      end else if (!m_en[i]) begin
        m_st[i] = 0;
      end else begin
        case (m_st[i])
          0: if (match) begin m_st[i] = 1; m_rt[i] = 0; irq = 1; end
          1: begin
            if (ack[i]) m_st[i] = 0;
            else if (SNZ && snooze[i]) begin m_st[i] = 2; m_sl[i] = SM * 60; end
            else if (tick) begin
              m_rt[i]++;
              if (m_rt[i] == int'(RS)) m_st[i] = 0;
            end
          end
          default: begin
            if (ack[i]) m_st[i] = 0;
            else if (tick) begin
              m_sl[i]--;
              if (m_sl[i] == 0) begin m_st[i] = 1; m_rt[i] = 0; irq = 1; end
            end
          end
        endcase
      end
    end
    m_irq = irq;
    if (ld_ok) begin
      m_t = int'(time_in[16:12]) * 3600 + int'(time_in[11:6]) * 60 + int'(time_in[5:0]);
      m_pend = 0; m_eod = 0;
    end else if (tick) begin
      m_t = (m_t + 1) % 86400;
      m_eod = (m_t == 0);
      m_pend = 1;
    end else begin
      m_pend = 0; m_eod = 0;
    end
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [NA-1:0] rv;
    for (int i = 0; i < NA; i++) rv[i] = (m_st[i] == 1);
    return {5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), m_eod, rv, m_irq};
  endfunction

  // ------------------------------------------------------------- helpers
  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [11:0] alm(input bit en, input int h, input int m);
    return {en, 5'(h), 6'(m)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset(); else model_update();
    #1;
    chk("model", 32'(dut_vec), 32'(model_out()));
  endtask

  task automatic drive(input logic tk, input logic ts, input logic [16:0] tin,
                       input logic wr, input logic [1:0] sel, input logic [11:0] ain,
                       input logic [NA-1:0] ak, input logic [NA-1:0] sz);
    tick = tk; time_set = ts; time_in = tin; alarm_wr = wr;
    alarm_sel = sel; alarm_in = ain; ack = ak; snooze = sz;
    cycle();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 2'd0, '0, '0, '0);
  endtask

  task automatic tk1();
    drive(1'b1, 1'b0, '0, 1'b0, 2'd0, '0, '0, '0);
  endtask

  // ------------------------------------------------------- vector table
  typedef struct {
    logic        tk;
    logic        ts;
    logic [16:0] tin;
    logic [16:0] exp_t;
    logic        exp_eod;
  } vec_t;
  vec_t tbl[$];

  function automatic void addv(input logic tk, input logic ts, input logic [16:0] tin,
                               input logic [16:0] et, input logic ee);
    vec_t v;
    v.tk = tk; v.ts = ts; v.tin = tin; v.exp_t = et; v.exp_eod = ee;
    tbl.push_back(v);
  endfunction

  initial begin
    int n_hi, n_irq;
    reset = 1'b1;
    tick = 0; time_set = 0; time_in = '0; alarm_wr = 0;
    alarm_sel = '0; alarm_in = '0; ack = '0; snooze = '0;
    model_reset();

    addv(0, 1, hms(25, 0, 0),   hms(0, 0, 0),   0); // invalid hour ignored
    addv(1, 0, '0,              hms(0, 0, 1),   0);
    addv(1, 1, hms(25, 0, 0),   hms(0, 0, 2),   0); // invalid load + tick -> tick
    addv(0, 1, hms(10, 60, 0),  hms(0, 0, 2),   0); // invalid minute
    addv(0, 1, hms(10, 0, 60),  hms(0, 0, 2),   0); // invalid second
    addv(0, 1, hms(23, 59, 58), hms(23, 59, 58), 0);
    addv(1, 0, '0,              hms(23, 59, 59), 0);
    addv(1, 0, '0,              hms(0, 0, 0),   1); // midnight rollover
    addv(0, 0, '0,              hms(0, 0, 0),   0);
    addv(0, 1, hms(23, 59, 59), hms(23, 59, 59), 0);
    addv(1, 1, hms(12, 34, 56), hms(12, 34, 56), 0); // load beats tick
    addv(0, 1, hms(23, 59, 59), hms(23, 59, 59), 0);
    addv(1, 1, hms(0, 0, 0),    hms(0, 0, 0),   0); // load to midnight: no pulse
    addv(1, 0, '0,              hms(0, 0, 1),   0);
    addv(0, 1, hms(1, 59, 59),  hms(1, 59, 59), 0);
    addv(1, 0, '0,              hms(2, 0, 0),   0); // full carry chain

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(dut_vec), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].tk, tbl[k].ts, tbl[k].tin, 1'b0, 2'd0, '0, '0, '0);
      chk("tbl_time", 32'({hour_out, min_out, sec_out}), 32'(tbl[k].exp_t));
      chk("tbl_eod", 32'(end_of_day), 32'(tbl[k].exp_eod));
    end

    // Channel 2 at 07:30: ring one clk after the matching tick, timeout after RS ticks.
    drive(0, 0, '0, 1, 2'd2, alm(1, 7, 30), '0, '0);
    drive(0, 1, hms(7, 29, 59), 0, 2'd0, '0, '0, '0);
    tk1();
    chk("ch2_not_yet", 32'(ringing[2]), 32'd0);
    idle();
    chk("ch2_ring", 32'(ringing[2]), 32'd1);
    chk("ch2_irq", 32'(alarm_irq), 32'd1);
    idle();
    chk("ch2_irq_once", 32'(alarm_irq), 32'd0);
    drive(0, 0, '0, 1, 2'd2, alm(1, 24, 0), '0, '0); // out-of-range write dropped
    chk("ch2_badwr", 32'(ringing[2]), 32'd1);
    n_hi = 0;
    repeat (RS - 1) begin
      tk1();
      if (ringing[2]) n_hi++;
    end
    chk("ch2_ring_held", 32'(n_hi), 32'(RS - 1));
    tk1();
    chk("ch2_timeout", 32'(ringing[2]), 32'd0);

    // Channel 0 at 08:00: ack and snooze together resolve as ack.
    drive(0, 0, '0, 1, 2'd0, alm(1, 8, 0), '0, '0);
    drive(0, 1, hms(7, 59, 59), 0, 2'd0, '0, '0, '0);
    tk1();
    idle();
    chk("ch0_ring", 32'(ringing[0]), 32'd1);
    drive(0, 0, '0, 0, 2'd0, '0, 4'b0001, 4'b0001);
    chk("ch0_ack", 32'(ringing[0]), 32'd0);
    drive(0, 0, '0, 0, 2'd0, '0, 4'b0001, 4'b0001);
    n_hi = 0; n_irq = 0;
    repeat (310) begin
      tk1();
      if (ringing[0]) n_hi++;
      if (alarm_irq) n_irq++;
    end
    chk("ch0_no_rering", 32'(n_hi), 32'd0);
    chk("ch0_no_irq", 32'(n_irq), 32'd0);

    // Channel 1 at 09:00: snooze behaviour.
    drive(0, 0, '0, 1, 2'd1, alm(1, 9, 0), '0, '0);
    drive(0, 1, hms(8, 59, 59), 0, 2'd0, '0, '0, '0);
    tk1();
    idle();
    chk("ch1_ring", 32'(ringing[1]), 32'd1);
    drive(0, 0, '0, 0, 2'd0, '0, '0, 4'b0010);
`ifdef RTC_ALARM_SNOOZE_EN
    chk("ch1_snoozed", 32'(ringing[1]), 32'd0);
    n_hi = 0;
    repeat (SM * 60 - 1) begin
      tk1();
      if (ringing[1]) n_hi++;
    end
    chk("ch1_quiet", 32'(n_hi), 32'd0);
    tk1();
    chk("ch1_rering", 32'(ringing[1]), 32'd1);
    chk("ch1_rering_irq", 32'(alarm_irq), 32'd1);
`else
    chk("ch1_snooze_ignored", 32'(ringing[1]), 32'd1);
`endif
    drive(0, 0, '0, 0, 2'd0, '0, 4'b0010, '0);
    chk("ch1_ack", 32'(ringing[1]), 32'd0);

    // Channels 0 and 3 at 12:00, reset mid-ring.
    drive(0, 0, '0, 1, 2'd0, alm(1, 12, 0), '0, '0);
    drive(0, 0, '0, 1, 2'd3, alm(1, 12, 0), '0, '0);
    drive(0, 1, hms(11, 59, 59), 0, 2'd0, '0, '0, '0);
    tk1();
    idle();
    chk("dual_ring", 32'(ringing), 32'(4'b1001));
    chk("dual_irq", 32'(alarm_irq), 32'd1);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("async_reset", 32'(dut_vec), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_held", 32'(dut_vec), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n_hi = 0; n_irq = 0;
    repeat (80) begin
      tk1();
      if (ringing != '0) n_hi++;
      if (alarm_irq) n_irq++;
    end
    chk("post_reset_ring", 32'(n_hi), 32'd0);
    chk("post_reset_irq", 32'(n_irq), 32'd0);

    // Randomized phase against the reference model.
    for (int c = 0; c < 4000; c++) begin
      logic tk, ts, wr;
      logic [16:0] tin;
      logic [1:0] sel;
      logic [11:0] ain;
      logic [NA-1:0] ak, sz;
      int tm, h, m;
      tk  = ($urandom_range(0, 1) == 0);
      ts  = ($urandom_range(0, 149) == 0);
      tin = hms(int'($urandom_range(0, 24)), int'($urandom_range(0, 60)),
                int'($urandom_range(45, 60)));
      wr  = ($urandom_range(0, 59) == 0);
      tm  = (m_t / 60 + int'($urandom_range(0, 2))) % 1440;
      h   = tm / 60;
      m   = tm % 60;
      if ($urandom_range(0, 15) == 0) h = 24 + int'($urandom_range(0, 7));
      ain = alm(($urandom_range(0, 3) != 0), h, m);
      sel = 2'($urandom_range(0, NA - 1));
      for (int i = 0; i < NA; i++) begin
        ak[i] = ($urandom_range(0, 47) == 0);
        sz[i] = ($urandom_range(0, 47) == 0);
      end
      drive(tk, ts, tin, wr, sel, ain, ak, sz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_alarm_bank.md
RTC_ALARM_BANK -- requirements
Module: rtc_alarm_bank

Interface
REQ-001 Parameter NUM_ALARMS, default 4: number of independent alarm channels, range 1..8.
REQ-002 Parameter RING_SECONDS, default 60: ticks an unacknowledged alarm rings before it clears itself, range 1..255.
REQ-003 Parameter SNOOZE_MIN, default 5: snooze length in minutes, range 1..59.
REQ-004 Derived localparam ASW = max(1, clog2(NUM_ALARMS)).
REQ-005 Port clk, input, 1: the single system clock.
REQ-006 Port reset, input, 1: asynchronous reset, active-high.
REQ-007 Port tick, input, 1: one-clk pulse that advances time by one second.
REQ-008 Port time_set, input, 1: load time_in on this clk.
REQ-009 Port time_in, input, 17: {hour[16:12], min[11:6], sec[5:0]} in binary.
REQ-010 Port alarm_wr, input, 1: write one alarm channel.
REQ-011 Port alarm_sel, input, ASW: index of the channel to write.
REQ-012 Port alarm_in, input, 12: {enable[11], hour[10:6], min[5:0]}.
REQ-013 Port ack, input, NUM_ALARMS: per-channel acknowledge, one bit per channel, level-sampled.
REQ-014 Port snooze, input, NUM_ALARMS: per-channel snooze request, one bit per channel, level-sampled.
REQ-015 Port hour_out, output, 5: current hour.
REQ-016 Port min_out, output, 6: current minute.
REQ-017 Port sec_out, output, 6: current second.
REQ-018 Port end_of_day, output, 1: one-clk pulse on the 23:59:59 to 00:00:00 rollover.
REQ-019 Port ringing, output, NUM_ALARMS: one bit per channel, high while that channel is in RINGING.
REQ-020 Port alarm_irq, output, 1: one-clk pulse when any channel enters RINGING.

Function
REQ-021 All outputs SHALL be registered; time outputs SHALL reflect a tick or load on the clk edge that samples it.
REQ-022 Seconds SHALL count 0..59; the carry SHALL advance minutes 0..59, whose carry SHALL advance hours 0..23, all in the same edge.
REQ-023 end_of_day SHALL be high for exactly the one clk on which the time registers become 00:00:00 from 23:59:59 via tick.
REQ-024 time_set SHALL have priority over tick in the same cycle, and a load SHALL never pulse end_of_day.
REQ-025 A time_in with hour>23, min>59 or sec>59 SHALL be ignored entirely, and time SHALL then advance on tick as if no load occurred.
REQ-026 alarm_wr SHALL store alarm_in into channel alarm_sel and force that channel to IDLE.
REQ-027 An out-of-range alarm_in (hour>23 or min>59), or alarm_sel>=NUM_ALARMS, SHALL be ignored.
REQ-028 Per-channel states SHALL be IDLE, RINGING and SNOOZE.
REQ-029 IDLE to RINGING SHALL occur one clk after a tick-driven update makes the time equal to hour:min:00 of an enabled channel; loads SHALL never trigger a match.
REQ-030 RINGING to IDLE SHALL occur on ack, or when RING_SECONDS ticks have elapsed in RINGING.
REQ-031 RINGING to SNOOZE SHALL occur on snooze; on entry the snooze counter SHALL load SNOOZE_MIN*60.
REQ-032 SNOOZE SHALL decrement its counter per tick and move to RINGING when the counter reaches 0; the ring counter SHALL restart on every RINGING entry.
REQ-033 ack and snooze asserted together SHALL resolve as ack; ack in SNOOZE SHALL return the channel to IDLE.
REQ-034 A channel whose enable bit is 0 SHALL be forced to IDLE from any state on the next clk.
REQ-035 A match arriving while a channel is already in RINGING or SNOOZE SHALL be ignored.
REQ-036 alarm_irq SHALL pulse once per clk in which one or more channels enter RINGING, including re-entry from SNOOZE.

Reset
REQ-037 On reset, time SHALL be 00:00:00; end_of_day, ringing and alarm_irq SHALL be 0.
REQ-038 On reset, all alarm registers SHALL be 0 (disabled), all FSMs IDLE and all counters 0.
REQ-039 Reset asserted mid-ring or mid-snooze SHALL abort immediately, with no alarm_irq pulse after release.

Configuration
REQ-040 Macro RTC_ALARM_SNOOZE_EN defined: the SNOOZE state, snooze counters and the snooze port function as specified above.
REQ-041 Macro RTC_ALARM_SNOOZE_EN undefined: the snooze port SHALL still exist but be ignored, no SNOOZE state or counter SHALL be built, and RINGING SHALL exit only via ack, timeout or disable.

Verification
REQ-042 Load 23:59:58, then 2 ticks -> time 23:59:59 then 00:00:00, with end_of_day high exactly 1 clk on the second tick.
REQ-043 Load 25:00:00 (invalid), then 1 tick -> time 00:00:01 from reset, and no end_of_day.
REQ-044 Alarm ch2 = 07:30 enabled; load 07:29:59, then 1 tick -> ringing[2] and alarm_irq high 1 clk later; with no ack, ringing[2] drops after 60 ticks.
REQ-045 Ch0 ringing, ack[0] and snooze[0] held together -> ch0 goes to IDLE with no re-ring after 300 ticks.
REQ-046 With snooze enabled: ch1 ringing, snooze[1] for 1 clk -> ringing[1] low; after 300 ticks, ringing[1] high again and alarm_irq pulses.
REQ-047 Channels 0 and 3 both set to 12:00, reset asserted mid-ring -> all outputs 0 and no alarm_irq after release.
